ctrl_pipe_chain: RTL and testbench
==================================

# ctrl_pipe_chain

Parametrised chain of pipeline control registers carrying the decoded control word (register write, memory write and read enables, writeback select, CSR read and write, mret) from decode through the later stages. It replaces the single-stage, single-stall control register with a STAGES-deep chain. Each stage has a valid bit, its own stall and flush, and inserts a bubble automatically. It also keeps saturating stall and flush event counters for performance monitoring.

## Interface
- WIDTH, 8: control word width; defaults to `ctrl_pipe_pkg::CTRL_W`.
- STAGES, 2: number of register stages (1..8).
- BUBBLE_VAL, '0: control value loaded whenever a stage holds a bubble.
- CNT_W, 16: width of each event counter.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- in_ctrl  in  WIDTH  control word entering stage 0.
- in_valid  in  1  in_ctrl is a real instruction.
- stall  in  STAGES  bit i: stage i must not advance this cycle.
- flush  in  STAGES  bit i: stage i is killed this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- out_ctrl  out  STAGES*WIDTH  stage i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  STAGES  per-stage valid.
- stall_cnt  out  CNT_W  cycles with any stall bit set.
- flush_cnt  out  CNT_W  cycles with any flush bit set.

## Operation
- hold[i] = OR of stall[STAGES-1:i]. A downstream stall freezes all upstream stages.
- Next state of stage i, in priority order:
  - flush[i]: load a bubble (valid=0, ctrl=BUBBLE_VAL). Flush beats stall.
  - hold[i]: keep the current contents.
  - i>0 and hold[i-1]: load a bubble. The upstream stage is stalled, so nothing advances into stage i.
  - Otherwise: load the upstream stage. Stage 0 loads in_ctrl/in_valid.
- When in_valid=0, stage 0 loads BUBBLE_VAL, not in_ctrl. Downstream logic never sees stale control on an invalid slot.
- stall, flush and in_valid have no X/Z special-casing. Unknown values are a protocol violation and are flagged by bench assertions.
- Counters:
  - stall_cnt increments when |stall is 1; flush_cnt increments when |flush is 1.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr has priority over an increment in the same cycle.
- Reset values:
  - All out_valid = 0 and all out_ctrl = BUBBLE_VAL.
  - stall_cnt = 0 and flush_cnt = 0.
  - Reset is asynchronous: asserting it mid-operation clears every stage immediately, not at the next edge.

## Timing
- Latency: an unstalled word sampled on edge n appears at stage k after edge n+k (stage 0 at edge n).
- All outputs are registered; there is no combinational path from input to output.
- stall and flush are sampled at the same edge they affect. Asserting stall[i] in cycle c keeps stage i's edge-c value through the end of cycle c.
- stall[i] alone produces exactly one bubble per stalled cycle in stage i+1 (when i < STAGES-1).
- flush[i] together with stall[j] for j>i: stage i becomes a bubble, and stages j..i+1 hold.
- Counters update at the same edge as the event and become visible the following cycle.

## Structure
- Package `ctrl_pipe_pkg` holds:
  - `ctrl_t`, a packed struct {reg_wr, wr_en, rd_en, wb_sel[1:0], csr_reg_wr, csr_reg_rd, is_mret};
  - `CTRL_W = $bits(ctrl_t)`;
  - `CTRL_BUBBLE`, the all-zero `ctrl_t`.
- Sub-module `ctrl_pipe_stage`: one stage register. Inputs are d/d_valid, hold, load_bubble and flush; outputs are q/q_valid. The top level instantiates it with a generate loop and contains the hold-chain logic and the two counters.

## Test plan
- Reset: hold reset=0 with random inputs toggling. Required: out_valid=2'b00, out_ctrl=0 and both counters 0. Then assert reset mid-stream with both stages valid. Required: outputs clear before the next clk edge.
- Free flow (STAGES=2): in_ctrl=8'hA5 with in_valid=1 at edge 0, then 8'h3C at edge 1. Required: stage 0 shows A5 then 3C; stage 1 shows A5 after edge 1 and 3C after edge 2.
- Downstream stall: stages hold 8'h11/8'h22, then stall[1]=1 for 3 cycles while in_ctrl changes. Required: both stages stay 11/22 and stall_cnt=3.
- Local stall: stall[0]=1 for 1 cycle with stages 11/22. Required: stage 0 stays 11; stage 1 becomes valid=0, ctrl=00; the next edge then moves 11 into stage 1.
- Flush vs stall: flush[1]=1 and stall[1]=1 in the same cycle. Required: stage 1 becomes a bubble, stage 0 holds, flush_cnt=1 and stall_cnt=1.
- Counter saturation (CNT_W=4): 20 consecutive stall cycles. Required: stall_cnt=15. Then cnt_clr=1 together with stall=1. Required: stall_cnt=0 after that edge.

Source files
------------

// File: rtl/ctrl_pipe_chain_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared types for the decoded-control pipeline chain.
//   ctrl_t      : decoded control word carried from decode into later stages
//   CTRL_W      : width of ctrl_t in bits
//   CTRL_BUBBLE : the all-zero control word (no side effects)
// ----------------------------------------------------------------------------
package ctrl_pipe_pkg;

  typedef struct packed {
    logic       reg_wr;      // integer register file write
    logic       wr_en;       // data memory write
    logic       rd_en;       // data memory read
    logic [1:0] wb_sel;      // writeback source select
    logic       csr_reg_wr;  // CSR write
    logic       csr_reg_rd;  // CSR read
    logic       is_mret;     // return from machine trap
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_chain_if
// Bus bundle of the control pipeline chain.
//   master : drives in_ctrl/in_valid/stall/flush/cnt_clr, observes the stages
//   slave  : the chain itself
// Signals:
//   in_ctrl   WIDTH         control word entering stage 0
//   in_valid  1             in_ctrl is a real instruction
//   stall     STAGES        bit i: stage i must not advance
//   flush     STAGES        bit i: stage i is killed
//   cnt_clr   1             synchronous clear of both event counters
//   out_ctrl  STAGES*WIDTH  stage i at [i*WIDTH +: WIDTH]
//   out_valid STAGES        per-stage valid
//   stall_cnt CNT_W         cycles with any stall bit set (saturating)
//   flush_cnt CNT_W         cycles with any flush bit set (saturating)
// ----------------------------------------------------------------------------
interface ctrl_pipe_chain_if
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH  = CTRL_W,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
);

  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    cnt_clr;
  logic [STAGES*WIDTH-1:0] out_ctrl;
  logic [STAGES-1:0]       out_valid;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output in_ctrl, in_valid, stall, flush, cnt_clr,
    input  out_ctrl, out_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_ctrl, in_valid, stall, flush, cnt_clr,
    output out_ctrl, out_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_stage
// One register stage of the control chain.
//   clk, reset   : clock, asynchronous active-low reset
//   d, d_valid   : upstream control word and its valid
//   hold         : keep current contents (this or a downstream stage stalled)
//   load_bubble  : upstream is held, so nothing advances into this stage
//   flush        : kill this stage (beats hold)
//   q, q_valid   : registered stage contents
// ----------------------------------------------------------------------------
module ctrl_pipe_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             hold,
  input  logic             load_bubble,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;

  // Stage register: flush > hold > bubble-in > advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r       <= BUBBLE_VAL;
      q_valid_r <= 1'b0;
    end else if (flush) begin
      q_r       <= BUBBLE_VAL;
      q_valid_r <= 1'b0;
    end else if (hold) begin
      q_r       <= q_r;
      q_valid_r <= q_valid_r;
    end else if (load_bubble || !d_valid) begin
      // An invalid slot always carries BUBBLE_VAL so no stale control leaks.
      q_r       <= BUBBLE_VAL;
      q_valid_r <= 1'b0;
    end else begin
      q_r       <= d;
      q_valid_r <= 1'b1;
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ----------------------------------------------------------------------------
// ctrl_pipe_chain
// STAGES-deep chain of decoded-control registers with per-stage valid, stall
// and flush, automatic bubble insertion, and saturating stall/flush counters.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : ctrl_pipe_chain_if.slave (inputs, stage outputs, counters)
// ----------------------------------------------------------------------------
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH      = CTRL_W,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_pipe_chain_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [STAGES-1:0] hold_s;
  logic [WIDTH-1:0]  q_s [STAGES];
  logic [STAGES-1:0] q_valid_s;
  logic              any_stall_s;
  logic              any_flush_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  // Hold chain: a stall anywhere downstream freezes every upstream stage.
  always_comb begin
    hold_s = {STAGES{1'b0}};
    hold_s[STAGES-1] = bus.stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold_s[i] = bus.stall[i] | hold_s[i+1];
    end
  end

  assign any_stall_s = |bus.stall;
  assign any_flush_s = |bus.flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] d_s;
    logic             d_valid_s;
    logic             load_bubble_s;

    if (g == 0) begin : g_head
      assign d_s           = bus.in_ctrl;
      assign d_valid_s     = bus.in_valid;
      assign load_bubble_s = 1'b0;
    end else begin : g_body
      assign d_s           = q_s[g-1];
      assign d_valid_s     = q_valid_s[g-1];
      // Upstream is frozen, so this stage receives a bubble.
      assign load_bubble_s = hold_s[g-1];
    end

    ctrl_pipe_stage #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .d           (d_s),
      .d_valid     (d_valid_s),
      .hold        (hold_s[g]),
      .load_bubble (load_bubble_s),
      .flush       (bus.flush[g]),
      .q           (q_s[g]),
      .q_valid     (q_valid_s[g])
    );
  end

  // Pack the registered stage contents onto the bus.
  always_comb begin
    bus.out_ctrl = {(STAGES*WIDTH){1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      bus.out_ctrl[i*WIDTH +: WIDTH] = q_s[i];
    end
  end

  assign bus.out_valid = q_valid_s;

  // Saturating event counters; clear beats an increment in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (any_stall_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (any_flush_s && !(&flush_cnt_r)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// ----------------------------------------------------------------------------
// tb_ctrl_pipe_chain
// Self-checking bench for ctrl_pipe_chain (WIDTH=8, STAGES=2, CNT_W=4).
// ----------------------------------------------------------------------------
module tb_ctrl_pipe_chain;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // reference state: per-stage valid/control and counter values
  int m_valid [S];
  int m_ctrl  [S];
  int m_scnt;
  int m_fcnt;

  ctrl_pipe_chain_if #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) bus ();

  ctrl_pipe_chain #(
    .WIDTH      (W),
    .STAGES     (S),
    .BUBBLE_VAL (8'h00),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs must never be unknown while out of reset.
  always @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown({bus.stall, bus.flush, bus.in_valid, bus.cnt_clr}))
      else $error("unknown stall/flush/in_valid/cnt_clr");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_valid[i] = 0;
      m_ctrl[i]  = 0;
    end
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [S*W-1:0] exp_ctrl;
    logic [S-1:0]   exp_valid;
    for (int i = 0; i < S; i++) begin
      exp_ctrl[i*W +: W] = W'(m_ctrl[i]);
      exp_valid[i]       = (m_valid[i] != 0);
    end
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_valid));
    chk({tag, ".ctrl"},  32'(bus.out_ctrl),  32'(exp_ctrl));
    chk({tag, ".scnt"},  32'(bus.stall_cnt), 32'(m_scnt));
    chk({tag, ".fcnt"},  32'(bus.flush_cnt), 32'(m_fcnt));
  endtask

  // One clock: apply the rules to the sampled inputs, then compare at +1.
  task automatic step(input string tag);
    int ic, iv, cc;
    int st [S];
    int fl [S];
    int held [S];
    int n_valid [S];
    int n_ctrl [S];
    int any_st, any_fl;
    ic = int'(bus.in_ctrl);
    iv = int'(bus.in_valid);
    cc = int'(bus.cnt_clr);
    any_st = 0;
    any_fl = 0;
    for (int i = 0; i < S; i++) begin
      st[i] = int'(bus.stall[i]);
      fl[i] = int'(bus.flush[i]);
      if (st[i] != 0) any_st = 1;
      if (fl[i] != 0) any_fl = 1;
    end
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < S; i++) begin
        held[i] = 0;
        for (int j = i; j < S; j++) if (st[j] != 0) held[i] = 1;
      end
      for (int i = 0; i < S; i++) begin
        if (fl[i] != 0) begin
          n_valid[i] = 0; n_ctrl[i] = 0;
        end else if (held[i] != 0) begin
          n_valid[i] = m_valid[i]; n_ctrl[i] = m_ctrl[i];
        end else if (i > 0 && held[i-1] != 0) begin
          n_valid[i] = 0; n_ctrl[i] = 0;
        end else if (i == 0) begin
          n_valid[i] = iv; n_ctrl[i] = (iv != 0) ? ic : 0;
        end else begin
          n_valid[i] = m_valid[i-1]; n_ctrl[i] = m_ctrl[i-1];
        end
      end
      for (int i = 0; i < S; i++) begin
        m_valid[i] = n_valid[i];
        m_ctrl[i]  = n_ctrl[i];
      end
      if (cc != 0) begin
        m_scnt = 0; m_fcnt = 0;
      end else begin
        if (any_st != 0 && m_scnt < MAX) m_scnt++;
        if (any_fl != 0 && m_fcnt < MAX) m_fcnt++;
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic [W-1:0] c, input logic v, input logic [S-1:0] st,
                       input logic [S-1:0] fl, input logic clr);
    bus.in_ctrl  = c;
    bus.in_valid = v;
    bus.stall    = st;
    bus.flush    = fl;
    bus.cnt_clr  = clr;
  endtask

  // Load stage1=22, stage0=11 and zero the counters.
  task automatic fill_11_22();
    drive(8'h22, 1'b1, 2'b00, 2'b00, 1'b1); step("fill0");
    drive(8'h11, 1'b1, 2'b00, 2'b00, 1'b1); step("fill1");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    reset = 1'b0;
    drive(8'h00, 1'b0, 2'b00, 2'b00, 1'b0);

    // Reset held with random inputs toggling.
    for (int k = 0; k < 4; k++) begin
      drive(W'($urandom), 1'($urandom), S'($urandom), S'($urandom), 1'($urandom));
      step("rst_hold");
    end
    #2 reset = 1'b1;

    // Free flow.
    drive(8'hA5, 1'b1, 2'b00, 2'b00, 1'b0); step("ff0");
    chk("ff0.s0", 32'(bus.out_ctrl[7:0]), 32'h0000_00A5);
    drive(8'h3C, 1'b1, 2'b00, 2'b00, 1'b0); step("ff1");
    chk("ff1.both", 32'(bus.out_ctrl), 32'h0000_A53C);
    drive(8'h77, 1'b0, 2'b00, 2'b00, 1'b0); step("ff2");
    chk("ff2.s1", 32'(bus.out_ctrl[15:8]), 32'h0000_003C);
    chk("ff2.valid", 32'(bus.out_valid), 32'h0000_0002);

    // Asynchronous reset mid-stream with both stages valid.
    drive(8'h5A, 1'b1, 2'b00, 2'b00, 1'b0); step("pre_ar0");
    drive(8'h6B, 1'b1, 2'b00, 2'b00, 1'b0); step("pre_ar1");
    chk("pre_ar.valid", 32'(bus.out_valid), 32'h0000_0003);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 reset = 1'b1;

    // Downstream stall.
    fill_11_22();
    for (int k = 0; k < 3; k++) begin
      drive(W'($urandom), 1'b1, 2'b10, 2'b00, 1'b0); step("dstall");
      chk("dstall.ctrl", 32'(bus.out_ctrl), 32'h0000_2211);
      chk("dstall.valid", 32'(bus.out_valid), 32'h0000_0003);
    end
    chk("dstall.scnt", 32'(bus.stall_cnt), 32'h0000_0003);

    // Local stall of stage 0.
    fill_11_22();
    drive(8'h99, 1'b1, 2'b01, 2'b00, 1'b0); step("lstall");
    chk("lstall.ctrl", 32'(bus.out_ctrl), 32'h0000_0011);
    chk("lstall.valid", 32'(bus.out_valid), 32'h0000_0001);
    drive(8'h99, 1'b0, 2'b00, 2'b00, 1'b0); step("lstall_next");
    chk("lstall_next.ctrl", 32'(bus.out_ctrl), 32'h0000_1100);
    chk("lstall_next.valid", 32'(bus.out_valid), 32'h0000_0002);

    // Flush beats stall on stage 1.
    fill_11_22();
    drive(8'h44, 1'b1, 2'b10, 2'b10, 1'b0); step("fvs");
    chk("fvs.ctrl", 32'(bus.out_ctrl), 32'h0000_0011);
    chk("fvs.valid", 32'(bus.out_valid), 32'h0000_0001);
    chk("fvs.fcnt", 32'(bus.flush_cnt), 32'h0000_0001);
    chk("fvs.scnt", 32'(bus.stall_cnt), 32'h0000_0001);

    // Counter saturation then clear with simultaneous stall.
    drive(8'h00, 1'b0, 2'b00, 2'b00, 1'b1); step("sat_clr");
    for (int k = 0; k < 20; k++) begin
      drive(W'($urandom), 1'($urandom), 2'b01, 2'b00, 1'b0); step("sat");
    end
    chk("sat.scnt", 32'(bus.stall_cnt), 32'h0000_000F);
    drive(8'h00, 1'b0, 2'b01, 2'b00, 1'b1); step("sat_clr2");
    chk("sat_clr2.scnt", 32'(bus.stall_cnt), 32'h0000_0000);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [S-1:0] st;
      logic [S-1:0] fl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 3) == 0);
        fl[i] = ($urandom_range(0, 5) == 0);
      end
      drive(W'($urandom), ($urandom_range(0, 3) != 0), st, fl, ($urandom_range(0, 39) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
